uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter: IRQ_LEVEL, 1, occupancy at or above which irq asserts; 1..DEPTH.
REQ-003 Port: sysclk  in  1  system clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: RX_STATUS  in  1  one-sysclk byte-valid pulse from the UART receiver.
REQ-006 Port: RX_DATA  in  8  received byte, valid while RX_STATUS is high.
REQ-007 Port: rd_en  in  1  CPU pop request, one entry per asserted cycle.
REQ-008 Port: clr_ovr  in  1  clears the overrun flag.
REQ-009 Port: rd_data  out  8  head entry; 0x00 when empty.
REQ-010 Port: empty  out  1  occupancy == 0.
REQ-011 Port: full  out  1  occupancy == DEPTH.
REQ-012 Port: level  out  clog2(DEPTH)+1  current occupancy.
REQ-013 Port: overrun  out  1  sticky flag: byte dropped because FIFO full.
REQ-014 Port: irq  out  1  level interrupt request (see Configuration).

Function
REQ-015 Push: RX_STATUS high and (not full or pop accepted same cycle) -> RX_DATA written at wr_ptr, wr_ptr increments.
REQ-016 Pop: rd_en high and not empty -> rd_ptr increments; rd_en while empty is ignored, no state change.
REQ-017 rd_data is first-word-fall-through: shows mem[rd_ptr] combinationally; new head visible the cycle after a pop.
REQ-018 Written byte visible on rd_data and counted in level the cycle after RX_STATUS.
REQ-019 Pointers clog2(DEPTH) bits, wrap DEPTH-1 -> 0 with no gap.
REQ-020 level: +1 push only, -1 pop only, unchanged on simultaneous push and pop or neither.
REQ-021 Full + RX_STATUS + rd_en: pop and push both accepted, level stays DEPTH, overrun unchanged.
REQ-022 Empty + RX_STATUS + rd_en: push accepted, pop ignored, level becomes 1.
REQ-023 Full + RX_STATUS, no rd_en: byte discarded, memory and pointers unchanged, overrun set next cycle.
REQ-024 overrun cleared by clr_ovr; same-cycle set and clear -> set wins.
REQ-025 empty, full derived from level; never simultaneously high.
REQ-026 RX_STATUS held high multiple cycles pushes once per cycle; upstream guarantees single pulses.

Reset
REQ-027 reset high -> immediately wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, overrun=0, irq=0, rd_data=0x00.
REQ-028 Reset mid-operation discards all stored bytes; RX_STATUS during reset is ignored.
REQ-029 Memory contents need not be reset; must be unobservable while empty.

Configuration
REQ-030 Macro UART_RX_IRQ_EN defined: irq = (level >= IRQ_LEVEL) | overrun, registered, asserted the cycle after the causing event.
REQ-031 Macro UART_RX_IRQ_EN undefined: irq tied 0, no interrupt logic synthesized; all other behaviour identical.

Verification
REQ-032 Reset, push 0x41,0x42,0x43 on spaced pulses, then 3 rd_en -> rd_data 0x41,0x42,0x43 in order, level 3->0, empty=1.
REQ-033 DEPTH=16: push 16 bytes -> full=1; 17th push 0xFF -> dropped, overrun=1; pop all -> no 0xFF; clr_ovr -> overrun=0.
REQ-034 Full FIFO, RX_STATUS(0x5A)+rd_en same cycle -> level stays 16, 0x5A appears as last entry after draining.
REQ-035 Empty FIFO, RX_STATUS(0x11)+rd_en same cycle -> level=1, rd_data=0x11 next cycle; rd_en on empty -> no change.
REQ-036 40 push/pop pairs through DEPTH=16 (pointer wrap twice) -> data order preserved, level never exceeds 16.
REQ-037 UART_RX_IRQ_EN, IRQ_LEVEL=4: 3 pushes -> irq=0; 4th -> irq=1 next cycle; reset asserted with 4 stored -> irq=0, empty=1 immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and the CPU: first-word-fall-through
// read port, sticky overrun flag, optional level interrupt enabled by macro UART_RX_IRQ_EN.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic                       RX_STATUS,
  input  logic [7:0]                 RX_DATA,
  input  logic                       rd_en,
  input  logic                       clr_ovr,
  output logic [7:0]                 rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic                       irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d;
  logic          push, pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_L);
  assign level   = level_q;
  assign overrun = overrun_q;
  // Empty gate keeps stale memory (never reset) off the read port.
  assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    pop       = rd_en & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    push      = RX_STATUS & (~full | pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (clr_ovr) overrun_d = 1'b0;
    if (RX_STATUS && !push) overrun_d = 1'b1;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= RX_DATA;
  end

`ifdef UART_RX_IRQ_EN
  localparam logic [LW-1:0] IRQ_LVL = LW'(IRQ_LEVEL);
  logic irq_q, irq_d;

  // Computed from next-state so irq rises the cycle after the causing event.
  always_comb begin
    irq_d = (level_d >= IRQ_LVL) | overrun_d;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, IRQ_LEVEL=4); irq expectations follow UART_RX_IRQ_EN.
module tb_uart_rx_fifo;

`ifdef UART_RX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       reset;
  logic       RX_STATUS;
  logic [7:0] RX_DATA;
  logic       rd_en;
  logic       clr_ovr;
  logic [7:0] rd_data;
  logic       empty, full, overrun, irq;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .IRQ_LEVEL(4)) dut (
    .sysclk(sysclk), .reset(reset), .RX_STATUS(RX_STATUS), .RX_DATA(RX_DATA),
    .rd_en(rd_en), .clr_ovr(clr_ovr), .rd_data(rd_data), .empty(empty),
    .full(full), .level(level), .overrun(overrun), .irq(irq)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    RX_STATUS = 1'b1; RX_DATA = b;
    tick();
    RX_STATUS = 1'b0; RX_DATA = 8'h00;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; RX_STATUS = 1'b0; RX_DATA = 8'h00; rd_en = 1'b0; clr_ovr = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rd_data, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick();

    // three spaced pushes, then drain in order
    push(8'h41); tick();
    push(8'h42); tick();
    push(8'h43); tick();
    chk("fill3_level", level, 3);
    chk("fill3_head", rd_data, 8'h41);
    chk("fill3_irq", irq, 0);
    pop();
    chk("pop1_head", rd_data, 8'h42);
    chk("pop1_level", level, 2);
    pop();
    chk("pop2_head", rd_data, 8'h43);
    chk("pop2_level", level, 1);
    pop();
    chk("pop3_level", level, 0);
    chk("pop3_empty", empty, 1);
    chk("pop3_rdata", rd_data, 8'h00);

    // pop on empty is ignored
    pop();
    chk("emptypop_level", level, 0);
    chk("emptypop_empty", empty, 1);

    // push+pop on empty: push wins, pop ignored
    RX_STATUS = 1'b1; RX_DATA = 8'h11; rd_en = 1'b1;
    tick();
    RX_STATUS = 1'b0; rd_en = 1'b0;
    chk("emptyboth_level", level, 1);
    chk("emptyboth_head", rd_data, 8'h11);
    pop();
    chk("emptyboth_drain", empty, 1);

    // fill to DEPTH, then overflow
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    chk("full_flag", full, 1);
    chk("full_level", level, 16);
    chk("full_empty", empty, 0);
    chk("full_irq", irq, IRQ_ON);
    push(8'hFF);
    chk("ovf_ovr", overrun, 1);
    chk("ovf_level", level, 16);
    chk("ovf_head", rd_data, 8'h60);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_ovr", overrun, 0);
    // same-cycle set and clear: set wins
    RX_STATUS = 1'b1; RX_DATA = 8'hFF; clr_ovr = 1'b1;
    tick();
    RX_STATUS = 1'b0; clr_ovr = 1'b0;
    chk("setwins_ovr", overrun, 1);
    chk("setwins_irq", irq, IRQ_ON);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr2_ovr", overrun, 0);

    // full + push + pop: both accepted
    RX_STATUS = 1'b1; RX_DATA = 8'h5A; rd_en = 1'b1;
    tick();
    RX_STATUS = 1'b0; rd_en = 1'b0;
    chk("fullboth_level", level, 16);
    chk("fullboth_ovr", overrun, 0);
    chk("fullboth_head", rd_data, 8'h61);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rd_data, (i < 15) ? 32'(8'h61 + i) : 32'h5A);
      pop();
    end
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);

    // streaming push/pop pairs with 3 in flight; pointers wrap
    push(8'h80); push(8'h81); push(8'h82);
    for (int i = 0; i < 40; i++) begin
      chk("stream_data", rd_data, 32'(8'(8'h80 + i)));
      RX_STATUS = 1'b1; RX_DATA = 8'(8'h83 + i); rd_en = 1'b1;
      tick();
      RX_STATUS = 1'b0; rd_en = 1'b0;
      chk("stream_level", level, 3);
    end
    for (int i = 0; i < 3; i++) begin
      chk("stream_tail", rd_data, 32'(8'hA8 + i));
      pop();
    end
    chk("stream_empty", empty, 1);

    // irq threshold and reset with bytes stored
    push(8'h01); push(8'h02); push(8'h03);
    chk("irq_below", irq, 0);
    push(8'h04);
    chk("irq_at", irq, IRQ_ON);
    chk("irq_level", level, 4);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_irq", irq, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_level", level, 0);
    chk("midrst_rdata", rd_data, 8'h00);
    RX_STATUS = 1'b1; RX_DATA = 8'h77;
    tick();
    RX_STATUS = 1'b0;
    chk("rstpush_level", level, 0);
    reset = 1'b0;
    tick();
    chk("postrst_empty", empty, 1);
    chk("postrst_rdata", rd_data, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
